// File: rtl/id_ex_pipe_reg.sv
// ----------------------------------------------------------------------------
// id_ex_pipe_reg
//
// ID/EX pipeline register. On each rising edge it either captures the
// decoded, NOP-filtered ID-stage bundle, holds its current contents, or
// loads a bubble. A bubble has every field at zero and Valid_EX low. It also
// keeps two saturating performance counters, one for bubbles and one for
// stall cycles.
//
// Edge priority: Flush_EX, then Stall_EX, then a normal load. A normal load
// with Valid_ID low also produces a bubble.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   Stall_EX            hold the current EX contents
//   Flush_EX            load a bubble on the next edge (overrides Stall_EX)
//   Valid_ID            the ID bundle holds a real instruction
//   Count_Clear         synchronous clear of both counters
//   *_ID_NOP / *_NOP    ID-stage bundle fields (inputs)
//   *_EX                registered bundle fields presented to EX (outputs)
//   Valid_EX            EX holds a real instruction
//   Bubble_Count        bubbles loaded since the last clear or reset
//   Stall_Count         stall cycles since the last clear or reset
// ----------------------------------------------------------------------------
module id_ex_pipe_reg #(
    parameter int XLEN      = 32,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 Stall_EX,
    input  logic                 Flush_EX,
    input  logic                 Valid_ID,
    input  logic                 Count_Clear,
    input  logic [XLEN-1:0]      Immediate_ID_NOP,
    input  logic [XLEN-1:0]      Operand1_NOP,
    input  logic [XLEN-1:0]      Operand2_NOP,
    input  logic [4:0]           Alu_Cntrl_ID_NOP,
    input  logic [XLEN-1:0]      Rout2_ID_NOP,
    input  logic [2:0]           Func3_ID_NOP,
    input  logic [6:0]           Immediate_Format_ID_NOP,
    input  logic [4:0]           rd_ID_NOP,
    input  logic                 Rs1_Valid_ID_NOP,
    input  logic                 Rs2_Valid_ID_NOP,
    input  logic                 Write_Enable_ID_NOP,
    input  logic [1:0]           WriteBack_Control_ID_NOP,
    output logic [XLEN-1:0]      Immediate_EX,
    output logic [XLEN-1:0]      Operand1_EX,
    output logic [XLEN-1:0]      Operand2_EX,
    output logic [4:0]           Alu_Cntrl_EX,
    output logic [XLEN-1:0]      Rout2_EX,
    output logic [2:0]           Func3_EX,
    output logic [6:0]           Immediate_Format_EX,
    output logic [4:0]           rd_EX,
    output logic                 Rs1_Valid_EX,
    output logic                 Rs2_Valid_EX,
    output logic                 Write_Enable_EX,
    output logic [1:0]           WriteBack_Control_EX,
    output logic                 Valid_EX,
    output logic [CNT_WIDTH-1:0] Bubble_Count,
    output logic [CNT_WIDTH-1:0] Stall_Count
);

    // Whole EX-side bundle kept in one packed register so that a bubble is a
    // single all-zero assignment and no field can be forgotten.
    typedef struct packed {
        logic [XLEN-1:0] immediate;
        logic [XLEN-1:0] operand1;
        logic [XLEN-1:0] operand2;
        logic [4:0]      alu_cntrl;
        logic [XLEN-1:0] rout2;
        logic [2:0]      func3;
        logic [6:0]      imm_format;
        logic [4:0]      rd;
        logic            rs1_valid;
        logic            rs2_valid;
        logic            write_enable;
        logic [1:0]      wb_control;
        logic            valid;
    } ex_bundle_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    ex_bundle_t             ex_q;
    ex_bundle_t             id_bundle;
    logic                   bubble_load;
    logic                   stall_hold;
    logic [CNT_WIDTH-1:0]   bubble_cnt_q;
    logic [CNT_WIDTH-1:0]   stall_cnt_q;

    // A bubble goes in on a flush, or on an unstalled edge with no valid
    // instruction in ID. A flush wins over a stall, so stall_hold excludes it.
    assign bubble_load = Flush_EX | (~Stall_EX & ~Valid_ID);
    assign stall_hold  = Stall_EX & ~Flush_EX;

    // The valid bit is forced high on capture. Capture only happens when
    // Valid_ID is high, so a captured write enable always comes with Valid_EX.
    assign id_bundle = '{
        immediate:    Immediate_ID_NOP,
        operand1:     Operand1_NOP,
        operand2:     Operand2_NOP,
        alu_cntrl:    Alu_Cntrl_ID_NOP,
        rout2:        Rout2_ID_NOP,
        func3:        Func3_ID_NOP,
        imm_format:   Immediate_Format_ID_NOP,
        rd:           rd_ID_NOP,
        rs1_valid:    Rs1_Valid_ID_NOP,
        rs2_valid:    Rs2_Valid_ID_NOP,
        write_enable: Write_Enable_ID_NOP,
        wb_control:   WriteBack_Control_ID_NOP,
        valid:        1'b1
    };

    // Pipeline register: bubble, hold or capture, in that order of priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else if (bubble_load) begin
            ex_q <= '0;
        end else if (!Stall_EX) begin
            ex_q <= id_bundle;
        end
    end

    // Performance counters. Clear beats a same-edge increment, and each
    // counter sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else if (Count_Clear) begin
            bubble_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            if (bubble_load && (bubble_cnt_q != CNT_MAX)) begin
                bubble_cnt_q <= bubble_cnt_q + CNT_ONE;
            end
            if (stall_hold && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            end
        end
    end

    assign Immediate_EX         = ex_q.immediate;
    assign Operand1_EX          = ex_q.operand1;
    assign Operand2_EX          = ex_q.operand2;
    assign Alu_Cntrl_EX         = ex_q.alu_cntrl;
    assign Rout2_EX             = ex_q.rout2;
    assign Func3_EX             = ex_q.func3;
    assign Immediate_Format_EX  = ex_q.imm_format;
    assign rd_EX                = ex_q.rd;
    assign Rs1_Valid_EX         = ex_q.rs1_valid;
    assign Rs2_Valid_EX         = ex_q.rs2_valid;
    assign Write_Enable_EX      = ex_q.write_enable;
    assign WriteBack_Control_EX = ex_q.wb_control;
    assign Valid_EX             = ex_q.valid;
    assign Bubble_Count         = bubble_cnt_q;
    assign Stall_Count          = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// ----------------------------------------------------------------------------
// tb_id_ex_pipe_reg
//
// Directed testbench for id_ex_pipe_reg. Two instances share every input:
// dut uses the default 32-bit counters, and dut4 uses 4-bit counters so that
// counter saturation can be reached in a few cycles. Expected values are
// hand-computed constants.
// ----------------------------------------------------------------------------
module tb_id_ex_pipe_reg;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            Stall_EX;
    logic            Flush_EX;
    logic            Valid_ID;
    logic            Count_Clear;
    logic [XLEN-1:0] Immediate_ID_NOP;
    logic [XLEN-1:0] Operand1_NOP;
    logic [XLEN-1:0] Operand2_NOP;
    logic [4:0]      Alu_Cntrl_ID_NOP;
    logic [XLEN-1:0] Rout2_ID_NOP;
    logic [2:0]      Func3_ID_NOP;
    logic [6:0]      Immediate_Format_ID_NOP;
    logic [4:0]      rd_ID_NOP;
    logic            Rs1_Valid_ID_NOP;
    logic            Rs2_Valid_ID_NOP;
    logic            Write_Enable_ID_NOP;
    logic [1:0]      WriteBack_Control_ID_NOP;

    logic [XLEN-1:0] Immediate_EX, Operand1_EX, Operand2_EX, Rout2_EX;
    logic [4:0]      Alu_Cntrl_EX, rd_EX;
    logic [2:0]      Func3_EX;
    logic [6:0]      Immediate_Format_EX;
    logic            Rs1_Valid_EX, Rs2_Valid_EX, Write_Enable_EX, Valid_EX;
    logic [1:0]      WriteBack_Control_EX;
    logic [31:0]     Bubble_Count, Stall_Count;

    logic [XLEN-1:0] imm4, op1_4, op2_4, rout2_4;
    logic [4:0]      alu4, rd4;
    logic [2:0]      func3_4;
    logic [6:0]      fmt4;
    logic            rs1v4, rs2v4, we4, valid4;
    logic [1:0]      wb4;
    logic [3:0]      bubble4, stall4;

    int numChecks = 0;
    int numErrors = 0;

    id_ex_pipe_reg #(.XLEN(XLEN), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .Stall_EX(Stall_EX), .Flush_EX(Flush_EX),
        .Valid_ID(Valid_ID), .Count_Clear(Count_Clear),
        .Immediate_ID_NOP(Immediate_ID_NOP), .Operand1_NOP(Operand1_NOP),
        .Operand2_NOP(Operand2_NOP), .Alu_Cntrl_ID_NOP(Alu_Cntrl_ID_NOP),
        .Rout2_ID_NOP(Rout2_ID_NOP), .Func3_ID_NOP(Func3_ID_NOP),
        .Immediate_Format_ID_NOP(Immediate_Format_ID_NOP), .rd_ID_NOP(rd_ID_NOP),
        .Rs1_Valid_ID_NOP(Rs1_Valid_ID_NOP), .Rs2_Valid_ID_NOP(Rs2_Valid_ID_NOP),
        .Write_Enable_ID_NOP(Write_Enable_ID_NOP),
        .WriteBack_Control_ID_NOP(WriteBack_Control_ID_NOP),
        .Immediate_EX(Immediate_EX), .Operand1_EX(Operand1_EX),
        .Operand2_EX(Operand2_EX), .Alu_Cntrl_EX(Alu_Cntrl_EX),
        .Rout2_EX(Rout2_EX), .Func3_EX(Func3_EX),
        .Immediate_Format_EX(Immediate_Format_EX), .rd_EX(rd_EX),
        .Rs1_Valid_EX(Rs1_Valid_EX), .Rs2_Valid_EX(Rs2_Valid_EX),
        .Write_Enable_EX(Write_Enable_EX),
        .WriteBack_Control_EX(WriteBack_Control_EX), .Valid_EX(Valid_EX),
        .Bubble_Count(Bubble_Count), .Stall_Count(Stall_Count)
    );

    id_ex_pipe_reg #(.XLEN(XLEN), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .Stall_EX(Stall_EX), .Flush_EX(Flush_EX),
        .Valid_ID(Valid_ID), .Count_Clear(Count_Clear),
        .Immediate_ID_NOP(Immediate_ID_NOP), .Operand1_NOP(Operand1_NOP),
        .Operand2_NOP(Operand2_NOP), .Alu_Cntrl_ID_NOP(Alu_Cntrl_ID_NOP),
        .Rout2_ID_NOP(Rout2_ID_NOP), .Func3_ID_NOP(Func3_ID_NOP),
        .Immediate_Format_ID_NOP(Immediate_Format_ID_NOP), .rd_ID_NOP(rd_ID_NOP),
        .Rs1_Valid_ID_NOP(Rs1_Valid_ID_NOP), .Rs2_Valid_ID_NOP(Rs2_Valid_ID_NOP),
        .Write_Enable_ID_NOP(Write_Enable_ID_NOP),
        .WriteBack_Control_ID_NOP(WriteBack_Control_ID_NOP),
        .Immediate_EX(imm4), .Operand1_EX(op1_4), .Operand2_EX(op2_4),
        .Alu_Cntrl_EX(alu4), .Rout2_EX(rout2_4), .Func3_EX(func3_4),
        .Immediate_Format_EX(fmt4), .rd_EX(rd4), .Rs1_Valid_EX(rs1v4),
        .Rs2_Valid_EX(rs2v4), .Write_Enable_EX(we4),
        .WriteBack_Control_EX(wb4), .Valid_EX(valid4),
        .Bubble_Count(bubble4), .Stall_Count(stall4)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compares one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numErrors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drives the control inputs, then waits one rising edge plus settling.
    task automatic applyStimulus(input logic stall, input logic flush,
                                 input logic valid, input logic clear);
        Stall_EX    = stall;
        Flush_EX    = flush;
        Valid_ID    = valid;
        Count_Clear = clear;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n                    = 1'b0;
        Stall_EX                 = 1'b0;
        Flush_EX                 = 1'b0;
        Count_Clear              = 1'b0;
        Valid_ID                 = 1'b1;
        Immediate_ID_NOP         = '0;
        Operand1_NOP             = 32'h1234_5678;
        Operand2_NOP             = '0;
        Alu_Cntrl_ID_NOP         = '0;
        Rout2_ID_NOP             = '0;
        Func3_ID_NOP             = '0;
        Immediate_Format_ID_NOP  = '0;
        rd_ID_NOP                = 5'd5;
        Rs1_Valid_ID_NOP         = 1'b0;
        Rs2_Valid_ID_NOP         = 1'b0;
        Write_Enable_ID_NOP      = 1'b1;
        WriteBack_Control_ID_NOP = '0;

        // Held in reset across a couple of edges: everything reads zero.
        #22;
        checkOutput("rst_op1",    64'(Operand1_EX), 64'h0);
        checkOutput("rst_rd",     64'(rd_EX), 64'h0);
        checkOutput("rst_we",     64'(Write_Enable_EX), 64'h0);
        checkOutput("rst_valid",  64'(Valid_EX), 64'h0);
        checkOutput("rst_bubble", 64'(Bubble_Count), 64'h0);
        checkOutput("rst_stall",  64'(Stall_Count), 64'h0);

        // Release between edges; the first edge afterwards loads.
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("load_op1",    64'(Operand1_EX), 64'h1234_5678);
        checkOutput("load_rd",     64'(rd_EX), 64'd5);
        checkOutput("load_we",     64'(Write_Enable_EX), 64'h1);
        checkOutput("load_valid",  64'(Valid_EX), 64'h1);
        checkOutput("load_bubble", 64'(Bubble_Count), 64'h0);

        // Stall hold: load A5A5A5A5, then stall for three edges with new inputs.
        Immediate_ID_NOP = 32'hA5A5_A5A5;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("imm_load", 64'(Immediate_EX), 64'hA5A5_A5A5);
        Immediate_ID_NOP = 32'hFFFF_FFFF;
        Operand1_NOP     = 32'h0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("stall_imm",    64'(Immediate_EX), 64'hA5A5_A5A5);
        checkOutput("stall_op1",    64'(Operand1_EX), 64'h1234_5678);
        checkOutput("stall_valid",  64'(Valid_EX), 64'h1);
        checkOutput("stall_count",  64'(Stall_Count), 64'd3);
        checkOutput("stall_bubble", 64'(Bubble_Count), 64'd0);

        // Flush together with stall: bubble wins, stall count unchanged.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("flush_imm",    64'(Immediate_EX), 64'h0);
        checkOutput("flush_rd",     64'(rd_EX), 64'h0);
        checkOutput("flush_we",     64'(Write_Enable_EX), 64'h0);
        checkOutput("flush_valid",  64'(Valid_EX), 64'h0);
        checkOutput("flush_bubble", 64'(Bubble_Count), 64'd1);
        checkOutput("flush_stall",  64'(Stall_Count), 64'd3);

        // Invalid ID with write enable set: still a bubble.
        Write_Enable_ID_NOP = 1'b1;
        rd_ID_NOP           = 5'd7;
        Immediate_ID_NOP    = 32'hDEAD_BEEF;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("inv_we",     64'(Write_Enable_EX), 64'h0);
        checkOutput("inv_rd",     64'(rd_EX), 64'h0);
        checkOutput("inv_imm",    64'(Immediate_EX), 64'h0);
        checkOutput("inv_valid",  64'(Valid_EX), 64'h0);
        checkOutput("inv_bubble", 64'(Bubble_Count), 64'd2);

        // Full-bundle capture with distinct values in every field.
        Immediate_ID_NOP         = 32'h1111_1111;
        Operand1_NOP             = 32'h2222_2222;
        Operand2_NOP             = 32'h3333_3333;
        Alu_Cntrl_ID_NOP         = 5'h1A;
        Rout2_ID_NOP             = 32'h4444_4444;
        Func3_ID_NOP             = 3'b101;
        Immediate_Format_ID_NOP  = 7'h63;
        rd_ID_NOP                = 5'd31;
        Rs1_Valid_ID_NOP         = 1'b1;
        Rs2_Valid_ID_NOP         = 1'b1;
        Write_Enable_ID_NOP      = 1'b0;
        WriteBack_Control_ID_NOP = 2'b10;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("full_imm",   64'(Immediate_EX), 64'h1111_1111);
        checkOutput("full_op1",   64'(Operand1_EX), 64'h2222_2222);
        checkOutput("full_op2",   64'(Operand2_EX), 64'h3333_3333);
        checkOutput("full_alu",   64'(Alu_Cntrl_EX), 64'h1A);
        checkOutput("full_rout2", 64'(Rout2_EX), 64'h4444_4444);
        checkOutput("full_func3", 64'(Func3_EX), 64'h5);
        checkOutput("full_fmt",   64'(Immediate_Format_EX), 64'h63);
        checkOutput("full_rd",    64'(rd_EX), 64'd31);
        checkOutput("full_rs1v",  64'(Rs1_Valid_EX), 64'h1);
        checkOutput("full_rs2v",  64'(Rs2_Valid_EX), 64'h1);
        checkOutput("full_we",    64'(Write_Enable_EX), 64'h0);
        checkOutput("full_wb",    64'(WriteBack_Control_EX), 64'h2);
        checkOutput("full_valid", 64'(Valid_EX), 64'h1);
        checkOutput("full_wb4",   64'(wb4), 64'h2);

        // Count_Clear on a normal load: counters zero, pipeline still loads.
        Operand1_NOP = 32'h5555_5555;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("clr_op1",    64'(Operand1_EX), 64'h5555_5555);
        checkOutput("clr_valid",  64'(Valid_EX), 64'h1);
        checkOutput("clr_bubble", 64'(Bubble_Count), 64'd0);
        checkOutput("clr_stall",  64'(Stall_Count), 64'd0);

        // Twenty stalls: the 4-bit counter sticks at 15, the 32-bit one reaches 20.
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("sat_stall4", 64'(stall4), 64'd15);
        checkOutput("sat_stall",  64'(Stall_Count), 64'd20);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("sat_hold4",  64'(stall4), 64'd15);
        checkOutput("sat_op1_4",  64'(op1_4), 64'h5555_5555);

        // Clear coincident with a stall wins over the increment.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("clrst_stall4", 64'(stall4), 64'd0);
        checkOutput("clrst_stall",  64'(Stall_Count), 64'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("post_clr_stall4", 64'(stall4), 64'd1);

        // Seventeen bubbles: 4-bit bubble counter sticks at 15.
        for (int i = 0; i < 17; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("sat_bubble4", 64'(bubble4), 64'd15);
        checkOutput("sat_bubble",  64'(Bubble_Count), 64'd17);
        checkOutput("sat_valid4",  64'(valid4), 64'h0);

        // Async reset mid-stall: outputs clear with no clock edge.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("pre_rst_valid", 64'(Valid_EX), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_valid",  64'(Valid_EX), 64'h0);
        checkOutput("arst_op1",    64'(Operand1_EX), 64'h0);
        checkOutput("arst_imm",    64'(Immediate_EX), 64'h0);
        checkOutput("arst_stall",  64'(Stall_Count), 64'h0);
        checkOutput("arst_bubble", 64'(Bubble_Count), 64'h0);
        checkOutput("arst_stall4", 64'(stall4), 64'h0);

        // Nothing pending survives: with stall still high, state stays zero.
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("post_rst_valid", 64'(Valid_EX), 64'h0);
        checkOutput("post_rst_stall", 64'(Stall_Count), 64'd1);

        $display("CHECKS %0d ERRORS %0d", numChecks, numErrors);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
ID/EX pipeline register. It captures the decoded, NOP-filtered ID-stage bundle (immediate, operands, ALU control, store data, func3, format, rd, valids, write-enable, writeback control) on each clock edge and presents it to EX. It supports hold (stall), bubble insertion (flush) and a valid bit. Two saturating performance counters record bubbles and stall cycles.

Parameters:
XLEN, 32, width of Immediate/Operand/Rout2 fields
CNT_WIDTH, 32, width of each performance counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
Stall_EX  in  1  hold current EX contents
Flush_EX  in  1  load bubble next edge
Valid_ID  in  1  ID bundle holds a real instruction
Count_Clear  in  1  synchronous clear of both counters
Immediate_ID_NOP in XLEN / Immediate_EX out XLEN  immediate
Operand1_NOP in XLEN / Operand1_EX out XLEN  ALU operand 1
Operand2_NOP in XLEN / Operand2_EX out XLEN  ALU operand 2
Alu_Cntrl_ID_NOP in 5 / Alu_Cntrl_EX out 5  ALU op select
Rout2_ID_NOP in XLEN / Rout2_EX out XLEN  store data
Func3_ID_NOP in 3 / Func3_EX out 3  func3
Immediate_Format_ID_NOP in 7 / Immediate_Format_EX out 7  format/opcode
rd_ID_NOP in 5 / rd_EX out 5  destination register address
Rs1_Valid_ID_NOP in 1 / Rs1_Valid_EX out 1  rs1 used
Rs2_Valid_ID_NOP in 1 / Rs2_Valid_EX out 1  rs2 used
Write_Enable_ID_NOP in 1 / Write_Enable_EX out 1  register-file write enable
WriteBack_Control_ID_NOP in 2 / WriteBack_Control_EX out 2  writeback mux select
Valid_EX  out  1  EX holds a real instruction
Bubble_Count  out  CNT_WIDTH  bubbles loaded since clear
Stall_Count  out  CNT_WIDTH  stall cycles since clear

Behaviour:
- Reset (rst_n=0, asynchronous): every output is 0, including counters. The first load occurs on the first rising edge after deassertion.
- Bubble definition: all field outputs are 0 and Valid_EX=0. Write_Enable_EX=0 guarantees no architectural effect.
- Per-edge priority is Flush_EX > Stall_EX > load:
  - Flush_EX=1: load a bubble regardless of Stall_EX.
  - Stall_EX=1 and Flush_EX=0: all registers hold their values.
  - Otherwise, if Valid_ID=1: capture all _NOP inputs and set Valid_EX=1.
  - Otherwise (Valid_ID=0): load a bubble. Input fields are ignored.
- Latency: one cycle from input to _EX output. No combinational path from inputs to outputs.
- Invariant: Write_Enable_EX=1 only when Valid_EX=1. If Write_Enable_ID_NOP=1 is captured, Valid_EX is also 1.
- Bubble_Count: +1 on each edge that loads a bubble (flush, or load with Valid_ID=0).
- Stall_Count: +1 on each edge with Stall_EX=1 and Flush_EX=0.
- Counters saturate at all-ones; they never wrap.
- Count_Clear=1: both counters go to 0 on that edge. Clear takes priority over a same-edge increment.
- Count_Clear does not affect pipeline state.
- Reset asserted mid-stall or mid-flush zeroes everything immediately. No pending state survives.

Test Plan:
- Reset then load: rst_n low, set Operand1_NOP=0x12345678, rd_ID_NOP=5, Write_Enable_ID_NOP=1, Valid_ID=1, then release -> one edge later Operand1_EX=0x12345678, rd_EX=5, Write_Enable_EX=1, Valid_EX=1. During reset all outputs read 0.
- Stall hold: load Immediate=0xA5A5A5A5, then Stall_EX=1 for 3 edges while inputs change to 0xFFFFFFFF -> Immediate_EX stays 0xA5A5A5A5 and Stall_Count=3.
- Flush vs stall: Stall_EX=1 and Flush_EX=1 together -> next edge all fields 0, Valid_EX=0, Bubble_Count+1, Stall_Count unchanged.
- Invalid ID: Valid_ID=0 with Write_Enable_ID_NOP=1, rd=7 -> Write_Enable_EX=0, rd_EX=0, Valid_EX=0, Bubble_Count+1.
- Saturation/clear (CNT_WIDTH=4 override): 20 stall cycles -> Stall_Count=15 and holds. Count_Clear coincident with a stall -> Stall_Count=0 next edge.
- Async reset mid-stall: assert rst_n low between edges while Stall_EX=1 -> outputs go to 0 immediately, with no clock edge needed.
